io_uart: RTL
============

# io_uart

Memory-mapped 8N1 UART peripheral that answers on the processor's 5-bit IO bus. The processor side decodes IO addresses 0x08–0x0F of the current bank into `{bank, addr[2:0]}`. This block claims one bank and returns registered read data one cycle after the address. It raises level interrupts on the `io_interrupts` lines that the interrupt controller masks with INTCON.

## Interface
Parameters:
- `BANK`, 2'd0: bank this block responds to (`io_*addr[4:3]`).
- `DIV_RESET`, 16'd433: reset value of the baud divisor. Bit period = DIV+1 clk cycles.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `pause` in 1: pipeline stall. While high, `io_readdata` holds and bus writes are ignored.
- `io_readaddr` in 5: read address `{bank, reg[2:0]}`.
- `io_readdata` out 8: registered read data.
- `io_writeaddr` in 5: write address.
- `io_writedata` in 8: write data.
- `io_write_en` in 1: write strobe.
- `irq_tx` out 1: level, `tx_done & tx_ie`.
- `irq_rx` out 1: level, `(rx_valid & rx_ie) | ((rx_overrun | rx_ferr) & err_ie)`.
- `uart_rx` in 1: serial input, asynchronous.
- `uart_tx` out 1: serial output, idle high.

## Operation
Register map (reg = addr[2:0]):
- 0 TXDATA
  - Write: if `!tx_busy`, latches the byte and starts a frame.
  - Write while busy: byte dropped, `tx_ovr` set.
  - Read: last accepted byte.
- 1 RXDATA: read-only, last good received byte.
- 2 STATUS
  - Bits: [0] tx_busy, [1] tx_done, [2] rx_valid, [3] rx_overrun, [4] rx_ferr, [5] tx_ovr, [7:6] 0.
  - Write: each 1 in bits [5:1] clears that bit; bit 0 is read-only.
- 3 CTRL: RW, [0] tx_ie, [1] rx_ie, [2] err_ie, [7:3] read 0.
- 4 DIVLO, 5 DIVHI: RW, 16-bit divisor.
- 6, 7: read 0; writes ignored.

Bus rules:
- A write is accepted when `io_write_en && !pause && io_writeaddr[4:3]==BANK`.
- Read register: on each edge with `!pause`, `io_readdata <=` the selected register if `io_readaddr[4:3]==BANK`, else 0.
- Reads have no side effects.

TX FSM (IDLE, START, DATA, STOP):
- Baud counter counts 0..DIV; a bit ends when counter==DIV.
- START drives 0, DATA shifts 8 bits LSB first, STOP drives 1.
- At the end of STOP: `tx_busy` clears, `tx_done` sets, FSM returns to IDLE.
- An accepted TXDATA write clears `tx_done`.

RX path:
- `uart_rx` passes through a 2-flop synchronizer, plus one more flop for edge detect.
- IDLE: a synchronized 1→0 transition enters START and loads the counter to wait `DIV>>1` cycles.
  - Sample high at mid-start → back to IDLE, no flags.
- DATA: 8 samples, each DIV+1 cycles apart, LSB first.
- STOP: sample at mid-stop.
  - Stop = 1 and `!rx_valid`: RXDATA ← byte, `rx_valid` set.
  - Stop = 1 and `rx_valid` already set: RXDATA unchanged, `rx_overrun` set.
  - Stop = 0: `rx_ferr` set, byte discarded.
  - In all cases return to IDLE. A stuck-low line does not retrigger, because a new falling edge is required.

Boundary rules:
- Hardware set and a W1C clear of the same bit in the same cycle: the set wins.
- DIV write mid-frame: takes effect at the next counter reload; the current bit completes with the old compare.
- DIV=0: one clk per bit, and the RX half-wait is 0.
- Reset mid-frame: both FSMs go to IDLE immediately and `uart_tx`=1.

## Timing
- Read latency: address presented at edge N; data valid after edge N (one cycle, synchronous-RAM style).
- Writes: register effect visible after the accepting edge.
- TX start: TXDATA accepted at edge N → `uart_tx`=0 from edge N+1.
  - Frame occupies 10·(DIV+1) cycles.
  - `tx_done`/`irq_tx` rise at edge N+1+10·(DIV+1).
- RX delivery: `rx_valid` rises about (DIV>>1)+9·(DIV+1)+3 cycles after the line falls (3 = synchronizer/edge delay).
- `irq_*` are combinational from registered flags, with no extra delay.
- Reset values:
  - `io_readdata`=0, `uart_tx`=1, `irq_tx`=0, `irq_rx`=0.
  - All STATUS/CTRL bits 0, TXDATA=RXDATA=0, DIV=`DIV_RESET`.

## Test plan
- Reset + readback, BANK=1: read addr 5'b01_100 → 0xB1 (DIV_RESET=433=0x1B1) next cycle; read addr 5'b00_100 → 0x00.
- TX frame, DIV=3: write 0xA5 to TXDATA.
  - `uart_tx`: 0 ×4, then 1,0,1,0,0,1,0,1 ×4 each, then 1 ×4.
  - STATUS=0x01 during the frame, 0x02 after.
  - With tx_ie=1, `irq_tx`=1 until STATUS is written with 0x02.
- TX while busy: second write 0x3C mid-frame → STATUS bit5=1, line still carries 0xA5, TXDATA reads 0xA5.
- RX good + overrun, DIV=3, rx_ie=1: send 0x5A → RXDATA=0x5A, STATUS=0x04, `irq_rx`=1. Send 0x11 without clearing → RXDATA=0x5A, STATUS=0x0C.
- RX errors:
  - Frame with stop=0 → `rx_ferr`; with err_ie=1, `irq_rx`=1; rx_valid stays 0.
  - 1-cycle low glitch → no flags.
  - Line held low → single ferr only.
- Pause + simultaneous events:
  - `pause`=1 with a TXDATA write → no frame starts and `io_readdata` holds.
  - W1C of rx_valid on the same edge as a new RX completion → rx_valid stays 1.

Source files
------------

// File: rtl/io_uart.sv
// 8N1 UART on the 5-bit IO bus: TXDATA/RXDATA/STATUS/CTRL/DIV registers, level IRQs.
// Read data registered one cycle after address; TX line starts one cycle after accepted write.
// No backpressure: TX write while busy is dropped (tx_ovr), RX byte while full is dropped (rx_overrun).
module io_uart #(
    parameter logic [1:0]  BANK      = 2'd0,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic [4:0] io_readaddr,
    output logic [7:0] io_readdata,
    input  logic [4:0] io_writeaddr,
    input  logic [7:0] io_writedata,
    input  logic       io_write_en,
    output logic       irq_tx,
    output logic       irq_rx,
    input  logic       uart_rx,
    output logic       uart_tx
);

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_DIVLO  = 3'd4;
    localparam logic [2:0] REG_DIVHI  = 3'd5;

    // Sticky STATUS flags; field order matches STATUS bits [5:1] so W1C data maps directly.
    typedef struct packed {
        logic tx_ovr;
        logic rx_ferr;
        logic rx_overrun;
        logic rx_valid;
        logic tx_done;
    } flags_t;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Programmer-visible registers
    logic [7:0]  tx_data;
    logic [7:0]  rx_data;
    logic [15:0] div;
    logic        tx_ie;
    logic        rx_ie;
    logic        err_ie;
    flags_t      flags;
    flags_t      fl_set;
    flags_t      fl_clr;

    // Bus decode
    logic        wr_acc;
    logic [2:0]  wr_reg;
    logic        wr_txdata;
    logic        tx_accept;
    logic        tx_drop;
    logic        wr_status;
    logic [7:0]  rd_mux;
    logic [7:0]  status;

    // TX path
    tx_state_t   tx_state;
    tx_state_t   tx_state_nx;
    logic        tx_pend;
    logic [15:0] tx_cnt;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_bitcnt;
    logic        tx_line;
    logic        tx_tick;
    logic        tx_launch;
    logic        tx_finish;
    logic        tx_busy;

    // RX path
    rx_state_t   rx_state;
    rx_state_t   rx_state_nx;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_s3;
    logic        rx_fall;
    logic [15:0] rx_cnt;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_bitcnt;
    logic        rx_tick;
    logic        rx_good;
    logic        rx_ovr_ev;
    logic        rx_ferr_ev;

    assign wr_acc    = io_write_en && !pause && (io_writeaddr[4:3] == BANK);
    assign wr_reg    = io_writeaddr[2:0];
    assign wr_txdata = wr_acc && (wr_reg == REG_TXDATA);
    assign wr_status = wr_acc && (wr_reg == REG_STATUS);
    assign tx_busy   = tx_pend || (tx_state != TX_IDLE);
    assign tx_accept = wr_txdata && !tx_busy;
    assign tx_drop   = wr_txdata && tx_busy;
    assign tx_tick   = (tx_cnt == 16'd0);
    assign rx_tick   = (rx_cnt == 16'd0);
    assign rx_fall   = rx_s3 && !rx_s2;

    assign status  = {2'b00, flags, tx_busy};
    assign irq_tx  = flags.tx_done & tx_ie;
    assign irq_rx  = (flags.rx_valid & rx_ie) | ((flags.rx_overrun | flags.rx_ferr) & err_ie);
    assign uart_tx = tx_line;

    // Configuration and data registers written from the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data <= 8'h00;
            div     <= DIV_RESET;
            tx_ie   <= 1'b0;
            rx_ie   <= 1'b0;
            err_ie  <= 1'b0;
        end else begin
            if (tx_accept)
                tx_data <= io_writedata;
            if (wr_acc && wr_reg == REG_CTRL) begin
                tx_ie  <= io_writedata[0];
                rx_ie  <= io_writedata[1];
                err_ie <= io_writedata[2];
            end
            if (wr_acc && wr_reg == REG_DIVLO)
                div[7:0] <= io_writedata;
            if (wr_acc && wr_reg == REG_DIVHI)
                div[15:8] <= io_writedata;
        end
    end

    // Flag set/clear sources; a clear never masks a same-cycle set
    always_comb begin
        fl_set            = '0;
        fl_set.tx_ovr     = tx_drop;
        fl_set.rx_ferr    = rx_ferr_ev;
        fl_set.rx_overrun = rx_ovr_ev;
        fl_set.rx_valid   = rx_good;
        fl_set.tx_done    = tx_finish;
        fl_clr            = wr_status ? flags_t'(io_writedata[5:1]) : '0;
        fl_clr.tx_done    = fl_clr.tx_done | tx_accept;
    end

    // Sticky STATUS flags
    always_ff @(posedge clk) begin
        if (reset)
            flags <= '0;
        else
            flags <= fl_set | (flags & ~fl_clr);
    end

    // Read mux
    always_comb begin
        rd_mux = 8'h00;
        case (io_readaddr[2:0])
            REG_TXDATA: rd_mux = tx_data;
            REG_RXDATA: rd_mux = rx_data;
            REG_STATUS: rd_mux = status;
            REG_CTRL:   rd_mux = {5'b00000, err_ie, rx_ie, tx_ie};
            REG_DIVLO:  rd_mux = div[7:0];
            REG_DIVHI:  rd_mux = div[15:8];
            default:    rd_mux = 8'h00;
        endcase
    end

    // Registered read port, frozen while the pipeline is paused
    always_ff @(posedge clk) begin
        if (reset)
            io_readdata <= 8'h00;
        else if (!pause)
            io_readdata <= (io_readaddr[4:3] == BANK) ? rd_mux : 8'h00;
    end

    // TX state register
    always_ff @(posedge clk) begin
        if (reset)
            tx_state <= TX_IDLE;
        else
            tx_state <= tx_state_nx;
    end

    // TX next state; a pending byte launches one cycle after it was accepted
    always_comb begin
        tx_state_nx = tx_state;
        tx_launch   = 1'b0;
        tx_finish   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_pend) begin
                    tx_state_nx = TX_START;
                    tx_launch   = 1'b1;
                end
            end
            TX_START: if (tx_tick) tx_state_nx = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bitcnt == 3'd7) tx_state_nx = TX_STOP;
            TX_STOP: begin
                if (tx_tick) begin
                    tx_state_nx = TX_IDLE;
                    tx_finish   = 1'b1;
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    // TX datapath: baud down-counter reloads from div at each bit boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_pend   <= 1'b0;
            tx_cnt    <= 16'd0;
            tx_shift  <= 8'h00;
            tx_bitcnt <= 3'd0;
            tx_line   <= 1'b1;
        end else begin
            if (tx_accept)
                tx_pend <= 1'b1;
            else if (tx_launch)
                tx_pend <= 1'b0;
            if (tx_state == TX_IDLE) begin
                if (tx_launch) begin
                    tx_line   <= 1'b0;
                    tx_cnt    <= div;
                    tx_shift  <= tx_data;
                    tx_bitcnt <= 3'd0;
                end
            end else if (!tx_tick) begin
                tx_cnt <= tx_cnt - 16'd1;
            end else begin
                tx_cnt <= div;
                case (tx_state)
                    TX_START: tx_line <= tx_shift[0];
                    TX_DATA: begin
                        if (tx_bitcnt == 3'd7) begin
                            tx_line <= 1'b1;
                        end else begin
                            tx_line   <= tx_shift[1];
                            tx_shift  <= tx_shift >> 1;
                            tx_bitcnt <= tx_bitcnt + 3'd1;
                        end
                    end
                    default: tx_line <= 1'b1;
                endcase
            end
        end
    end

    // RX synchronizer plus edge-detect stage
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (reset)
            rx_state <= RX_IDLE;
        else
            rx_state <= rx_state_nx;
    end

    // RX next state and frame-completion events
    always_comb begin
        rx_state_nx = rx_state;
        rx_good     = 1'b0;
        rx_ovr_ev   = 1'b0;
        rx_ferr_ev  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_nx = RX_START;
            RX_START: if (rx_tick) rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bitcnt == 3'd7) rx_state_nx = RX_STOP;
            RX_STOP: begin
                if (rx_tick) begin
                    rx_state_nx = RX_IDLE;
                    if (!rx_s2)
                        rx_ferr_ev = 1'b1;
                    else if (flags.rx_valid)
                        rx_ovr_ev = 1'b1;
                    else
                        rx_good = 1'b1;
                end
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    // RX datapath: half-bit wait into the start bit, then full-bit spacing
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt    <= 16'd0;
            rx_shift  <= 8'h00;
            rx_bitcnt <= 3'd0;
            rx_data   <= 8'h00;
        end else begin
            if (rx_state == RX_IDLE) begin
                if (rx_fall)
                    rx_cnt <= div >> 1;
            end else if (!rx_tick) begin
                rx_cnt <= rx_cnt - 16'd1;
            end else begin
                rx_cnt <= div;
                if (rx_state == RX_START)
                    rx_bitcnt <= 3'd0;
                if (rx_state == RX_DATA) begin
                    rx_shift  <= {rx_s2, rx_shift[7:1]};
                    rx_bitcnt <= rx_bitcnt + 3'd1;
                end
            end
            if (rx_good)
                rx_data <= rx_shift;
        end
    end

endmodule
